// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings for the LEGv8 control path: FSM states, opcode classes, ALU and
// sign-extend selects, opcode match patterns and the per-class EXEC control bundle.
package legv8_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    R_AND, R_ORR, R_ADD, R_SUB, I_ADD, I_SUB, B, CBZ, LDUR, STUR, MOVZ, ILLEGAL
  } opclass_e;

  localparam logic [3:0] ALUOP_AND   = 4'b0000;
  localparam logic [3:0] ALUOP_ORR   = 4'b0001;
  localparam logic [3:0] ALUOP_ADD   = 4'b0010;
  localparam logic [3:0] ALUOP_SUB   = 4'b0110;
  localparam logic [3:0] ALUOP_PASSB = 4'b0111;

  localparam logic [1:0] SIGNOP_ALU = 2'b00;
  localparam logic [1:0] SIGNOP_D   = 2'b01;
  localparam logic [1:0] SIGNOP_B   = 2'b10;
  localparam logic [1:0] SIGNOP_CB  = 2'b11;

  // '?' bits belong to immediate/register fields and are ignored by casez.
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_ADDI = 11'b1001000100?;
  localparam logic [10:0] OPC_SUBI = 11'b1101000100?;
  localparam logic [10:0] OPC_B    = 11'b000101?????;
  localparam logic [10:0] OPC_CBZ  = 11'b10110100???;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;
  localparam logic [10:0] OPC_MOVZ = 11'b110100101??;

  typedef struct packed {
    logic [3:0] aluop;
    logic       alusrc;
    logic [1:0] signop;
    logic       reg2loc;
  } exec_ctrl_t;

  function automatic exec_ctrl_t exec_ctrl(input opclass_e cls);
    exec_ctrl_t c;
    c = '0;
    case (cls)
      R_AND: c.aluop = ALUOP_AND;
      R_ORR: c.aluop = ALUOP_ORR;
      R_ADD: c.aluop = ALUOP_ADD;
      R_SUB: c.aluop = ALUOP_SUB;
      I_ADD: begin
        c.aluop  = ALUOP_ADD;
        c.alusrc = 1'b1;
        c.signop = SIGNOP_ALU;
      end
      I_SUB: begin
        c.aluop  = ALUOP_SUB;
        c.alusrc = 1'b1;
        c.signop = SIGNOP_ALU;
      end
      B: c.signop = SIGNOP_B;
      CBZ: begin
        c.aluop   = ALUOP_PASSB;
        c.signop  = SIGNOP_CB;
        c.reg2loc = 1'b1;
      end
      LDUR: begin
        c.aluop  = ALUOP_ADD;
        c.alusrc = 1'b1;
        c.signop = SIGNOP_D;
      end
      STUR: begin
        c.aluop   = ALUOP_ADD;
        c.alusrc  = 1'b1;
        c.signop  = SIGNOP_D;
        c.reg2loc = 1'b1;
      end
      MOVZ: begin
        c.aluop  = ALUOP_PASSB;
        c.alusrc = 1'b1;
        c.signop = SIGNOP_ALU;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational mapping of the 11-bit LEGv8 opcode field onto an instruction class.
// Shared by the single-cycle and multi-cycle control paths.
module opcode_class_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [10:0] opcode_i,
  output opclass_e    class_o
);

  always_comb begin
    class_o = ILLEGAL;
    casez (opcode_i)
      OPC_AND:  class_o = R_AND;
      OPC_ORR:  class_o = R_ORR;
      OPC_ADD:  class_o = R_ADD;
      OPC_SUB:  class_o = R_SUB;
      OPC_ADDI: class_o = I_ADD;
      OPC_SUBI: class_o = I_SUB;
      OPC_B:    class_o = B;
      OPC_CBZ:  class_o = CBZ;
      OPC_LDUR: class_o = LDUR;
      OPC_STUR: class_o = STUR;
      OPC_MOVZ: class_o = MOVZ;
      default:  class_o = ILLEGAL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the LEGv8 subset datapath, with
// memory-timeout and illegal-opcode traps. Define MC_PERF_CNT_EN to add cycle/instruction counters.
module multicycle_control
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        run,
  input  logic [10:0] opcode,
  input  logic        zero,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        ir_write,
  output logic        dmem_req,
  output logic        memread,
  output logic        memwrite,
  output logic        reg2loc,
  output logic        alusrc,
  output logic        mem2reg,
  output logic        regwrite,
  output logic [3:0]  aluop,
  output logic [1:0]  signop,
  output logic        pc_write,
  output logic        pc_src,
  output logic [2:0]  state,
  output logic        trap
`ifdef MC_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
`endif
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e     state_q, state_d;
  opclass_e   cls_q, cls_d;
  opclass_e   dec_cls;
  logic [7:0] cnt_q, cnt_d;
  exec_ctrl_t ec;
  logic       req_ok;

  opcode_class_decode u_decode (
    .opcode_i (opcode),
    .class_o  (dec_cls)
  );

  assign ec = exec_ctrl(cls_q);
  // The fetch request follows run, but is held off while reset is asserted so every output is 0.
  assign req_ok = run & resetl;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q <= FETCH;
      cls_q   <= R_AND;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  // The wait counter is zero on entry to FETCH/MEM, because every other path leaves cnt_d at its default.
  // A ready in the final allowed cycle is checked first, so it beats the timeout.
  always_comb begin
    state_d  = state_q;
    cls_d    = cls_q;
    cnt_d    = '0;
    imem_req = 1'b0;
    ir_write = 1'b0;
    dmem_req = 1'b0;
    memread  = 1'b0;
    memwrite = 1'b0;
    reg2loc  = 1'b0;
    alusrc   = 1'b0;
    mem2reg  = 1'b0;
    regwrite = 1'b0;
    aluop    = '0;
    signop   = '0;
    pc_write = 1'b0;
    pc_src   = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = req_ok;
        if (req_ok && imem_ready) begin
          ir_write = 1'b1;
          state_d  = DECODE;
        end else if (req_ok) begin
          if (cnt_q == TIMEOUT_LAST) state_d = TRAP;
          else cnt_d = cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q;
        end
      end
      DECODE: begin
        cls_d   = dec_cls;
        state_d = (dec_cls == ILLEGAL) ? TRAP : EXEC;
      end
      EXEC: begin
        aluop   = ec.aluop;
        alusrc  = ec.alusrc;
        signop  = ec.signop;
        reg2loc = ec.reg2loc;
        case (cls_q)
          B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
            state_d  = FETCH;
          end
          CBZ: begin
            pc_write = 1'b1;
            pc_src   = zero;
            state_d  = FETCH;
          end
          LDUR, STUR: state_d = MEM;
          default:    state_d = WB;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        memread  = (cls_q == LDUR);
        memwrite = (cls_q == STUR);
        if (dmem_ready) begin
          if (cls_q == LDUR) begin
            state_d = WB;
          end else begin
            pc_write = 1'b1;
            state_d  = FETCH;
          end
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WB: begin
        regwrite = 1'b1;
        mem2reg  = (cls_q == LDUR);
        pc_write = 1'b1;
        state_d  = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  assign state = state_q;
  assign trap  = (state_q == TRAP);

`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, instr_cnt_q;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != TRAP) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (pc_write)        instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into an expected
// cycle-by-cycle plan from its class and memory wait counts, then replayed against the DUT.
module tb_multicycle_control;

  localparam int T = 4;

  localparam int C_AND  = 0;
  localparam int C_ORR  = 1;
  localparam int C_ADD  = 2;
  localparam int C_SUB  = 3;
  localparam int C_ADDI = 4;
  localparam int C_SUBI = 5;
  localparam int C_B    = 6;
  localparam int C_CBZ  = 7;
  localparam int C_LDUR = 8;
  localparam int C_STUR = 9;
  localparam int C_MOVZ = 10;
  localparam int C_ILL  = 11;

  typedef struct packed {
    logic [2:0] state;
    logic       trap;
    logic       imem_req;
    logic       ir_write;
    logic       dmem_req;
    logic       memread;
    logic       memwrite;
    logic       reg2loc;
    logic       alusrc;
    logic       mem2reg;
    logic       regwrite;
    logic [3:0] aluop;
    logic [1:0] signop;
    logic       pc_write;
    logic       pc_src;
  } outs_t;

  typedef struct packed {
    logic        run;
    logic        imem_ready;
    logic        dmem_ready;
    logic        zero;
    logic [10:0] opcode;
  } stim_t;

  typedef struct packed {
    stim_t s;
    outs_t o;
  } cyc_t;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        run;
  logic [10:0] opcode;
  logic        zero;
  logic        imem_ready;
  logic        dmem_ready;
  logic        imem_req, ir_write, dmem_req, memread, memwrite;
  logic        reg2loc, alusrc, mem2reg, regwrite;
  logic [3:0]  aluop;
  logic [1:0]  signop;
  logic        pc_write, pc_src;
  logic [2:0]  state;
  logic        trap;
`ifdef MC_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  cyc_t plan[$];
  int   total  = 0;
  int   passed = 0;

  always #5 CLK = ~CLK;

  multicycle_control #(.MEM_TIMEOUT(T)) dut (
    .CLK        (CLK),
    .resetl     (resetl),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .imem_ready (imem_ready),
    .dmem_ready (dmem_ready),
    .imem_req   (imem_req),
    .ir_write   (ir_write),
    .dmem_req   (dmem_req),
    .memread    (memread),
    .memwrite   (memwrite),
    .reg2loc    (reg2loc),
    .alusrc     (alusrc),
    .mem2reg    (mem2reg),
    .regwrite   (regwrite),
    .aluop      (aluop),
    .signop     (signop),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .state      (state),
    .trap       (trap)
`ifdef MC_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt)
`endif
  );

  function automatic logic [10:0] patVal(input int cls);
    case (cls)
      C_AND:   return 11'b10001010000;
      C_ORR:   return 11'b10101010000;
      C_ADD:   return 11'b10001011000;
      C_SUB:   return 11'b11001011000;
      C_ADDI:  return 11'b10010001000;
      C_SUBI:  return 11'b11010001000;
      C_B:     return 11'b00010100000;
      C_CBZ:   return 11'b10110100000;
      C_LDUR:  return 11'b11111000010;
      C_STUR:  return 11'b11111000000;
      C_MOVZ:  return 11'b11010010100;
      default: return 11'b00000000000;
    endcase
  endfunction

  function automatic logic [10:0] patMask(input int cls);
    case (cls)
      C_ADDI, C_SUBI: return 11'b11111111110;
      C_B:            return 11'b11111100000;
      C_CBZ:          return 11'b11111111000;
      C_MOVZ:         return 11'b11111111100;
      default:        return 11'b11111111111;
    endcase
  endfunction

  function automatic bit isLegal(input logic [10:0] op);
    for (int i = 0; i < C_ILL; i++)
      if ((op & patMask(i)) == patVal(i)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [10:0] makeOpcode(input int cls);
    logic [10:0] r;
    if (cls == C_ILL) begin
      do r = 11'($urandom); while (isLegal(r));
      return r;
    end
    r = 11'($urandom);
    return (patVal(cls) & patMask(cls)) | (r & ~patMask(cls));
  endfunction

  function automatic outs_t sampleOuts();
    outs_t o;
    o.state    = state;
    o.trap     = trap;
    o.imem_req = imem_req;
    o.ir_write = ir_write;
    o.dmem_req = dmem_req;
    o.memread  = memread;
    o.memwrite = memwrite;
    o.reg2loc  = reg2loc;
    o.alusrc   = alusrc;
    o.mem2reg  = mem2reg;
    o.regwrite = regwrite;
    o.aluop    = aluop;
    o.signop   = signop;
    o.pc_write = pc_write;
    o.pc_src   = pc_src;
    return o;
  endfunction

  // Expected cycles of one instruction: fetch waits, decode, exec, optional memory waits, write-back.
  task automatic planInstr(input int cls, input logic [10:0] opc, input int iwait,
                           input int dwait, input logic z, input int trapCycles);
    cyc_t c;
    c = '0;
    c.s.run    = 1'b1;
    c.s.zero   = z;
    c.s.opcode = opc;
    for (int k = 0; k < iwait; k++) begin
      c.o = '0;
      c.o.imem_req = 1'b1;
      plan.push_back(c);
    end
    c.s.imem_ready = 1'b1;
    c.o = '0;
    c.o.imem_req = 1'b1;
    c.o.ir_write = 1'b1;
    plan.push_back(c);
    c.s.imem_ready = 1'b0;
    c.o = '0;
    c.o.state = 3'd1;
    plan.push_back(c);
    if (cls == C_ILL) begin
      for (int k = 0; k < trapCycles; k++) begin
        c.s.imem_ready = 1'($urandom);
        c.s.dmem_ready = 1'($urandom);
        c.o = '0;
        c.o.state = 3'd7;
        c.o.trap  = 1'b1;
        plan.push_back(c);
      end
      return;
    end
    c.o = '0;
    c.o.state = 3'd2;
    case (cls)
      C_AND:  c.o.aluop = 4'b0000;
      C_ORR:  c.o.aluop = 4'b0001;
      C_ADD:  c.o.aluop = 4'b0010;
      C_SUB:  c.o.aluop = 4'b0110;
      C_ADDI: begin c.o.aluop = 4'b0010; c.o.alusrc = 1'b1; end
      C_SUBI: begin c.o.aluop = 4'b0110; c.o.alusrc = 1'b1; end
      C_B:    begin c.o.signop = 2'b10; c.o.pc_write = 1'b1; c.o.pc_src = 1'b1; end
      C_CBZ:  begin
        c.o.aluop = 4'b0111; c.o.signop = 2'b11; c.o.reg2loc = 1'b1;
        c.o.pc_write = 1'b1; c.o.pc_src = z;
      end
      C_LDUR: begin c.o.aluop = 4'b0010; c.o.alusrc = 1'b1; c.o.signop = 2'b01; end
      C_STUR: begin
        c.o.aluop = 4'b0010; c.o.alusrc = 1'b1; c.o.signop = 2'b01; c.o.reg2loc = 1'b1;
      end
      C_MOVZ: begin c.o.aluop = 4'b0111; c.o.alusrc = 1'b1; end
      default: ;
    endcase
    plan.push_back(c);
    if (cls == C_B || cls == C_CBZ) return;
    if (cls == C_LDUR || cls == C_STUR) begin
      c.o = '0;
      c.o.state    = 3'd3;
      c.o.dmem_req = 1'b1;
      c.o.memread  = (cls == C_LDUR);
      c.o.memwrite = (cls == C_STUR);
      for (int k = 0; k < dwait && k < T; k++) plan.push_back(c);
      if (dwait >= T) begin
        for (int k = 0; k < trapCycles; k++) begin
          c.o = '0;
          c.o.state = 3'd7;
          c.o.trap  = 1'b1;
          plan.push_back(c);
        end
        return;
      end
      c.s.dmem_ready = 1'b1;
      c.o.pc_write   = (cls == C_STUR);
      plan.push_back(c);
      c.s.dmem_ready = 1'b0;
      if (cls == C_STUR) return;
    end
    c.o = '0;
    c.o.state    = 3'd4;
    c.o.regwrite = 1'b1;
    c.o.mem2reg  = (cls == C_LDUR);
    c.o.pc_write = 1'b1;
    plan.push_back(c);
  endtask

  task automatic applyStimulus(input stim_t s, output outs_t obs);
    run        = s.run;
    imem_ready = s.imem_ready;
    dmem_ready = s.dmem_ready;
    zero       = s.zero;
    opcode     = s.opcode;
    @(negedge CLK);
    obs = sampleOuts();
    @(posedge CLK);
    #1;
  endtask

  task automatic resetDut();
    resetl     = 1'b0;
    run        = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    zero       = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    resetl = 1'b1;
  endtask

  task automatic test_reset();
    outs_t obs;
    resetl     = 1'b0;
    run        = 1'b1;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    zero       = 1'b1;
    opcode     = 11'($urandom);
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      obs = sampleOuts();
      total++;
      if (obs !== outs_t'('0)) $display("[TB] FAIL reset_outputs: got %h want %h", obs, outs_t'('0));
      else passed++;
    end
`ifdef MC_PERF_CNT_EN
    total++;
    if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0)
      $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", cycle_cnt, instr_cnt);
    else passed++;
`endif
    @(posedge CLK);
    #1;
    resetl = 1'b1;
  endtask

  task automatic test_add();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_ADD, 11'b10001011000, 0, 0, 1'b0, 0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL add cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
  endtask

  task automatic test_ldur_wait();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_LDUR, 11'b11111000010, 0, 3, 1'b0, 0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL ldur_wait cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
  endtask

  task automatic test_cbz();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_CBZ, makeOpcode(C_CBZ), 0, 0, 1'b1, 0);
    planInstr(C_CBZ, makeOpcode(C_CBZ), 0, 0, 1'b0, 0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL cbz cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
  endtask

  task automatic test_run_low();
    stim_t s;
    outs_t obs;
    for (int k = 0; k < 2 * T; k++) begin
      s = '0;
      s.imem_ready = 1'($urandom);
      s.dmem_ready = 1'($urandom);
      s.opcode     = 11'($urandom);
      applyStimulus(s, obs);
      total++;
      if (obs !== outs_t'('0)) $display("[TB] FAIL run_low cycle %0d: got %h want %h", k, obs, outs_t'('0));
      else passed++;
    end
  endtask

  task automatic test_random();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    int    cls;
    for (int i = 0; i < 40; i++) begin
      cls = $urandom_range(C_MOVZ, C_AND);
      planInstr(cls, makeOpcode(cls), $urandom_range(T - 1, 0), $urandom_range(T - 1, 0),
                1'($urandom), 0);
    end
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL random cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
  endtask

  task automatic test_fetch_timeout();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_MOVZ, makeOpcode(C_MOVZ), T - 1, 0, 1'b0, 0);
    c = '0;
    c.s.run    = 1'b1;
    c.o.imem_req = 1'b1;
    for (int k = 0; k < T; k++) plan.push_back(c);
    c.o = '0;
    c.o.state = 3'd7;
    c.o.trap  = 1'b1;
    for (int k = 0; k < 4; k++) plan.push_back(c);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL fetch_timeout cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
    resetDut();
  endtask

  task automatic test_mem_timeout();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_STUR, 11'b11111000000, 0, T, 1'b0, 6);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL mem_timeout cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
    resetDut();
  endtask

  task automatic test_illegal();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_ILL, 11'b00000000000, 0, 0, 1'b0, 100);
    for (int i = 0; i < 3; i++) planInstr(C_ILL, makeOpcode(C_ILL), 0, 0, 1'b0, 3);
    for (int i = 0; i < 4; i++) begin
      while (plan.size() > 0 && !(n > 0 && plan[0].o.state == 3'd0 && plan[0].o.ir_write == 1'b0
                                  && plan[0].o.imem_req == 1'b1 && i > 0 && 0)) begin
        c = plan.pop_front();
        applyStimulus(c.s, obs);
        total++;
        if (obs !== c.o) $display("[TB] FAIL illegal cycle %0d: got %h want %h", n, obs, c.o);
        else passed++;
        n++;
        if (c.o.trap && (plan.size() == 0 || !plan[0].o.trap)) break;
      end
      #2;
      resetl = 1'b0;
      #1;
      obs = sampleOuts();
      total++;
      if (obs !== outs_t'('0)) $display("[TB] FAIL illegal_reset %0d: got %h want %h", i, obs, outs_t'('0));
      else passed++;
      @(posedge CLK);
      #1;
      resetl = 1'b1;
    end
  endtask

  task automatic test_reset_mid_mem();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    planInstr(C_LDUR, 11'b11111000010, 0, 3, 1'b0, 0);
    for (int k = 0; k < 4; k++) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL mid_mem cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
    plan.delete();
    #3;
    resetl = 1'b0;
    #1;
    obs = sampleOuts();
    total++;
    if (obs !== outs_t'('0)) $display("[TB] FAIL mid_mem_reset: got %h want %h", obs, outs_t'('0));
    else passed++;
    @(posedge CLK);
    #1;
    resetl = 1'b1;
    planInstr(C_B, makeOpcode(C_B), 0, 0, 1'b0, 0);
    planInstr(C_STUR, makeOpcode(C_STUR), 1, 2, 1'b1, 0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL after_reset cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
  endtask

`ifdef MC_PERF_CNT_EN
  task automatic test_perf();
    cyc_t  c;
    outs_t obs;
    int    n = 0;
    resetDut();
    for (int i = 0; i < 10; i++) planInstr(C_B, makeOpcode(C_B), 0, 0, 1'($urandom), 0);
    while (plan.size() > 0) begin
      c = plan.pop_front();
      applyStimulus(c.s, obs);
      total++;
      if (obs !== c.o) $display("[TB] FAIL perf cycle %0d: got %h want %h", n, obs, c.o);
      else passed++;
      n++;
    end
    total++;
    if (instr_cnt !== 32'd10) $display("[TB] FAIL instr_cnt: got %0d want 10", instr_cnt);
    else passed++;
    total++;
    if (cycle_cnt !== 32'd30) $display("[TB] FAIL cycle_cnt: got %0d want 30", cycle_cnt);
    else passed++;
  endtask
`endif

  initial begin
    resetl     = 1'b0;
    run        = 1'b0;
    opcode     = '0;
    zero       = 1'b0;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbz();
    test_run_low();
    test_random();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_mem();
`ifdef MC_PERF_CNT_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got %0d/%0d checks", passed, total);
    $fatal(1, "[TB] watchdog");
  end

endmodule
